// File: rtl/coin_pkg.sv
// Purpose : shared coin definitions for the conditioner and the downstream accumulator.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: coin_t channel index enum, NUM_COINS, coin values in cents, coin_value() lookup.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2
  } coin_t;

  localparam int NUM_COINS = 3;

  localparam int COIN_VALUE_NICKEL  = 5;
  localparam int COIN_VALUE_DIME    = 10;
  localparam int COIN_VALUE_QUARTER = 25;

  // Value in cents for a channel; used by the accumulator.
  function automatic int coin_value(input coin_t c);
    case (c)
      COIN_NICKEL:  return COIN_VALUE_NICKEL;
      COIN_DIME:    return COIN_VALUE_DIME;
      COIN_QUARTER: return COIN_VALUE_QUARTER;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Purpose : coin pulse bus between the input conditioner and the accumulator.
// Latency : n/a (wires only).
// Backpressure : hold from the accumulator suppresses pulses; coins stay buffered upstream.
// Signals: hold, clr_overflow (accumulator -> conditioner);
//          nickel, dime, quarter, overflow, busy (conditioner -> accumulator).
interface coin_input_conditioner_if;
  logic hold;
  logic clr_overflow;
  logic nickel;
  logic dime;
  logic quarter;
  logic overflow;
  logic busy;

  // master: the conditioner producing pulses
  modport master (
    input  hold,
    input  clr_overflow,
    output nickel,
    output dime,
    output quarter,
    output overflow,
    output busy
  );

  // slave: the accumulator consuming pulses
  modport slave (
    output hold,
    output clr_overflow,
    input  nickel,
    input  dime,
    input  quarter,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/coin_debounce.sv
// Purpose : one coin channel: 2-flop sync, debounce counter, insert-edge detect.
// Latency : insert_o fires on the edge the debounced level goes active, DEBOUNCE_CYCLES+2 edges after the raw line is first sampled.
// Backpressure : none; runs freely every cycle.
// Ports: clk, reset_n (async active-low), raw_n_i (raw active-low sensor), insert_o (1-cycle combinational insert strobe).
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n_i,
  output logic insert_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;   // debounced level, active-low like the sensor
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any agreement between synced value and level restarts the count, so a
  // mismatch must persist DEBOUNCE_CYCLES consecutive edges to be accepted.
  always_comb begin
    level_d  = level_q;
    cnt_d    = '0;
    insert_o = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d  = sync2_q;
        // Only the inactive->active (1->0) transition is a coin.
        insert_o = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Purpose : turns three bouncy async coin sensors into clean one-hot coin pulses.
// Latency : pulse register sets DEBOUNCE_CYCLES+3 edges after the raw line is first sampled (uncontended, hold=0).
// Backpressure : hold=1 stops grants; coins buffer up to PEND_MAX per channel, extra coins set sticky overflow.
// Ports: clk, reset_n (async active-low), coin_raw_n[2:0] (bit0 nickel, bit1 dime, bit2 quarter, active-low),
//        bus (master): hold, clr_overflow in; nickel, dime, quarter, overflow, busy out.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PEND_MAX        = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_COINS-1:0]     coin_raw_n,
  coin_input_conditioner_if.master bus
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  logic [NUM_COINS-1:0] insert;
  logic [NUM_COINS-1:0] gnt;
  logic [PW-1:0]        pend_q [NUM_COINS];
  logic [PW-1:0]        pend_d [NUM_COINS];
  logic [NUM_COINS-1:0] pulse_q;
  logic                 ovf_q, ovf_d;
  logic                 ovf_set;
  logic                 busy_q, busy_d;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_chan
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_n_i  (coin_raw_n[g]),
      .insert_o (insert[g])
    );
  end

  // Fixed priority quarter > dime > nickel, off the registered counts so the
  // grant never depends on a same-cycle insert.
  always_comb begin
    gnt = '0;
    if (!bus.hold) begin
      if (pend_q[COIN_QUARTER] != '0)     gnt[COIN_QUARTER] = 1'b1;
      else if (pend_q[COIN_DIME] != '0)   gnt[COIN_DIME]    = 1'b1;
      else if (pend_q[COIN_NICKEL] != '0) gnt[COIN_NICKEL]  = 1'b1;
    end
  end

  always_comb begin
    ovf_set = 1'b0;
    busy_d  = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      pend_d[i] = pend_q[i];
      if (insert[i] && !gnt[i]) begin
        // A full channel drops the coin; a same-cycle grant makes room instead.
        if (pend_q[i] == PEND_FULL) ovf_set = 1'b1;
        else                        pend_d[i] = pend_q[i] + PW'(1);
      end else if (!insert[i] && gnt[i]) begin
        pend_d[i] = pend_q[i] - PW'(1);
      end
      if (pend_d[i] != '0) busy_d = 1'b1;
    end
    // Set wins over a simultaneous clear.
    if (ovf_set)               ovf_d = 1'b1;
    else if (bus.clr_overflow) ovf_d = 1'b0;
    else                       ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COINS; i++) pend_q[i] <= '0;
      pulse_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COINS; i++) pend_q[i] <= pend_d[i];
      pulse_q <= gnt;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.nickel   = pulse_q[COIN_NICKEL];
  assign bus.dime     = pulse_q[COIN_DIME];
  assign bus.quarter  = pulse_q[COIN_QUARTER];
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Purpose : directed self-checking bench for coin_input_conditioner (DEBOUNCE_CYCLES=4, PEND_MAX=3).
// Latency : n/a.
// Backpressure : exercises hold and overflow directly.
module tb_coin_input_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] coin_raw_n;

  coin_input_conditioner_if bus ();

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PEND_MAX       (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin_raw_n (coin_raw_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ecnt = 0;
  int n_cnt, d_cnt, q_cnt;
  int n_last, d_last, q_last, q_first;
  int busy_cnt, multi;
  int e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_cnt = 0; d_cnt = 0; q_cnt = 0;
    n_last = -1; d_last = -1; q_last = -1; q_first = -1;
    busy_cnt = 0; multi = 0;
  endtask

  // Advance n edges, sampling outputs 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt++;
      if (bus.nickel === 1'b1) begin n_cnt++; n_last = ecnt; end
      if (bus.dime === 1'b1) begin d_cnt++; d_last = ecnt; end
      if (bus.quarter === 1'b1) begin
        q_cnt++; q_last = ecnt;
        if (q_first < 0) q_first = ecnt;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if ((int'(bus.nickel) + int'(bus.dime) + int'(bus.quarter)) > 1) multi++;
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    coin_raw_n       = 3'b111;
    bus.hold         = 1'b0;
    bus.clr_overflow = 1'b0;
    #1;
    check("rst_nickel",   bus.nickel,   0);
    check("rst_dime",     bus.dime,     0);
    check("rst_quarter",  bus.quarter,  0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy",     bus.busy,     0);
    step(3);
    reset_n = 1'b1;
    step(3);

    // 1: single dime, pulse after E7, busy for one cycle
    clr_mon();
    e0 = ecnt;
    coin_raw_n = 3'b101;
    step(20);
    check("t1_dime_cnt",  d_cnt, 1);
    check("t1_dime_edge", d_last - e0, 7);
    check("t1_nickel",    n_cnt, 0);
    check("t1_quarter",   q_cnt, 0);
    check("t1_busy_cyc",  busy_cnt, 1);
    coin_raw_n = 3'b111;
    step(10);

    // 2: nickel bounce (3 low / 1 high twice) then stable low
    clr_mon();
    for (int k = 0; k < 2; k++) begin
      coin_raw_n = 3'b110; step(3);
      coin_raw_n = 3'b111; step(1);
    end
    coin_raw_n = 3'b110;
    e0 = ecnt;
    step(20);
    check("t2_nickel_cnt",  n_cnt, 1);
    check("t2_nickel_edge", n_last - e0, 7);
    coin_raw_n = 3'b111;
    step(10);

    // 3: all three at once -> quarter, dime, nickel on consecutive cycles
    clr_mon();
    e0 = ecnt;
    coin_raw_n = 3'b000;
    step(15);
    check("t3_q_edge", q_last - e0, 7);
    check("t3_d_edge", d_last - e0, 8);
    check("t3_n_edge", n_last - e0, 9);
    check("t3_counts", n_cnt + d_cnt + q_cnt, 3);
    check("t3_onehot", multi, 0);
    coin_raw_n = 3'b111;
    step(10);

    // 4: hold, five quarters, overflow on the fourth
    clr_mon();
    bus.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      coin_raw_n = 3'b011;
      step(10);
      if (k == 2) check("t4_ovf_after3", bus.overflow, 0);
      if (k == 3) check("t4_ovf_after4", bus.overflow, 1);
      coin_raw_n = 3'b111;
      step(10);
    end
    check("t4_no_pulse_hold", q_cnt, 0);
    check("t4_busy_hold",     bus.busy, 1);
    bus.hold = 1'b0;
    step(5);
    check("t4_q_cnt",    q_cnt, 3);
    check("t4_q_consec", q_last - q_first, 2);
    check("t4_busy_end", bus.busy, 0);
    check("t4_ovf_held", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    step(1);
    bus.clr_overflow = 1'b0;
    check("t4_ovf_clr", bus.overflow, 0);

    // 5: reset with two dimes pending and a nickel mid-debounce
    clr_mon();
    bus.hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      coin_raw_n = 3'b101; step(10);
      coin_raw_n = 3'b111; step(10);
    end
    coin_raw_n = 3'b110;
    step(3);
    check("t5_busy_pre", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_busy_rst",  bus.busy, 0);
    check("t5_pulse_rst", {bus.nickel, bus.dime, bus.quarter}, 0);
    coin_raw_n = 3'b111;
    bus.hold   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clr_mon();
    step(20);
    check("t5_no_pulses", n_cnt + d_cnt + q_cnt, 0);
    check("t5_busy_post", bus.busy, 0);

    // 6: quarter held through reset -> one pulse D+3 edges after release
    reset_n    = 1'b0;
    coin_raw_n = 3'b011;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clr_mon();
    e0 = ecnt;
    step(15);
    check("t6_q_cnt",  q_cnt, 1);
    check("t6_q_edge", q_last - e0, D + 3);
    check("t6_others", n_cnt + d_cnt, 0);
    coin_raw_n = 3'b111; step(10);
    coin_raw_n = 3'b011; step(10);
    check("t6_q_repress", q_cnt, 2);
    coin_raw_n = 3'b111; step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Upstream stage of the vending-machine accumulator. Takes three raw, bouncy, asynchronous coin-sensor lines (nickel, dime, quarter) and delivers clean single-cycle coin pulses in the clk domain.
- Per coin sensor: synchronise, debounce, then detect the insert edge.
- Coins that arrive together are buffered per channel. They are emitted at most one coin per cycle, so the outputs are always one-hot or zero.
- Downstream stalls via hold. Buffer overflow raises a sticky overflow flag.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synced cycles a new level must persist before it is accepted; minimum 2.
- PEND_MAX, 3, maximum coins buffered per channel; saturating count.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- coin_raw_n  input  3  raw sensors, active-low; bit0 nickel, bit1 dime, bit2 quarter
- hold  input  1  1 = emit no pulses; buffered coins are retained
- clr_overflow  input  1  synchronous clear of overflow
- nickel  output  1  one-cycle pulse per accepted nickel
- dime  output  1  one-cycle pulse per accepted dime
- quarter  output  1  one-cycle pulse per accepted quarter
- overflow  output  1  sticky; a coin was dropped
- busy  output  1  1 while any channel has pending > 0

Behaviour:
- Clock and reset: clk; reset reset_n, asynchronous, active-low. All state is cleared on reset.
- Reset values:
  - Synchroniser flops = 1 (inactive).
  - Debounced level = inactive; debounce counters = 0; pending = 0.
  - nickel, dime, quarter, overflow, busy = 0.
- Reset mid-operation: pending coins and debounce progress are discarded; no pulse is emitted after reset_n deasserts until a new insertion completes debounce.
- Synchroniser: two flops per channel on coin_raw_n.
- Debounce, per channel, with s = synced value and L = debounced level:
  - If s == L, the counter is cleared.
  - If s != L, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s != L, then L <= s and counter <= 0.
  - Net effect: a mismatch must persist for DEBOUNCE_CYCLES consecutive edges. Shorter glitches are rejected and the counter restarts.
- Insert event: L transitions inactive->active. Release (active->inactive) is debounced identically but produces no event.
- A sensor held active through reset yields exactly one coin after reset_n deasserts and debounce completes.
- Pending counters, width $clog2(PEND_MAX+1), per channel:
  - +1 on an insert event.
  - -1 when that channel is granted.
  - Event and grant on the same edge: count unchanged.
- Saturation: an event arriving at pending == PEND_MAX with no same-cycle grant is dropped and sets overflow = 1.
- overflow stays 1 until clr_overflow. If set and clear occur on the same edge, set wins.
- Arbiter: when hold = 0, grant one channel with pending > 0. Fixed priority: quarter > dime > nickel.
- Outputs are registered. A grant at edge N drives its output pulse high during cycle N..N+1 only.
- No grant while hold = 1. hold affects only output generation; debounce and buffering continue.
- Latency, uncontended, hold = 0:
  - Raw line first sampled active at edge E1.
  - Synced value reaches s at E2; mismatch is counted on edges E3..E(2+D), where D = DEBOUNCE_CYCLES.
  - L flips and pending increments at E(2+D); the pulse register sets at E(3+D), i.e. D+3 edges after E1.
- busy is registered: (any pending != 0) after each edge.

Decomposition:
- coin_pkg, shared with the accumulator:
  - typedef enum coin_t {COIN_NICKEL = 0, COIN_DIME = 1, COIN_QUARTER = 2}.
  - NUM_COINS = 3.
  - Coin value constants 5, 10, 25.
- Sub-module coin_debounce: 2-flop sync, debounce counter and insert-edge detect for one channel, parameterised by DEBOUNCE_CYCLES. Instantiated NUM_COINS times.
- Pending counters, arbiter and output registers stay in the top level.

Test Plan:
1. DEBOUNCE_CYCLES=4; dime line low from E1 for 20 cycles -> dime high for exactly one cycle after E7; nickel and quarter stay 0; busy high for one cycle.
2. Nickel line bounces low 3 cycles / high 1 cycle twice, then stays low -> exactly one nickel pulse, occurring 7 edges after the start of the final stable low.
3. All three lines go low on the same edge -> quarter, dime and nickel pulses on three consecutive cycles, in that order; never two outputs high together.
4. hold = 1; insert 5 quarters (press/release each, debounced) -> no pulses, overflow = 1 after the 4th, busy = 1. Release hold -> exactly 3 quarter pulses on consecutive cycles, then busy = 0. clr_overflow -> overflow = 0.
5. Assert reset_n = 0 while pending dime = 2 and a nickel is mid-debounce -> all outputs 0 immediately; no pulses after release unless a line is re-asserted.
6. Coin line held low through reset -> exactly one pulse D+3 edges after reset_n rises; release and re-press -> a second pulse.
